floatingpoint_divider: RTL and testbench



---
 rtl/fp32_pkg.sv | 41 ++++
 rtl/floatingpoint_divider_if.sv | 22 ++
 rtl/floatingpoint_divider_mant_iter.sv | 67 ++++++
 rtl/floatingpoint_divider.sv | 115 +++++++++++
 tb/tb_floatingpoint_divider.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 constants, field slices, operand classification and the
// divider state encoding. The FP32 multiplier is expected to move onto it too.
package fp32_pkg;

  localparam int          FP32_BIAS = 127;
  localparam int          EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_NORMALIZE,
    ST_DONE
  } fpdiv_state_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp32_class_t;

  // Zero ignores the mantissa because subnormals are not supported.
  function automatic fp32_class_t fp32_classify(input logic [31:0] x);
    fp32_class_t c;
    logic [7:0]  e;
    logic [22:0] m;
    e      = x[EXP_MSB:EXP_LSB];
    m      = x[MAN_MSB:MAN_LSB];
    c.zero = (e == 8'd0);
    c.inf  = (e == 8'(EXP_MAX)) && (m == '0);
    c.nan  = (e == 8'(EXP_MAX)) && (m != '0);
    return c;
  endfunction

endpackage

// File: rtl/floatingpoint_divider_if.sv
// Operand handshake and result bus of the FP32 divider.
interface floatingpoint_divider_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] dataA_i;
  logic [DATA_WIDTH-1:0] dataB_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  dbz_o;

  modport master (
    output valid_i, dataA_i, dataB_i,
    input  ready_o, data_o, valid_o, dbz_o
  );

  modport slave (
    input  valid_i, dataA_i, dataB_i,
    output ready_o, data_o, valid_o, dbz_o
  );
endinterface

// File: rtl/floatingpoint_divider_mant_iter.sv
// Restoring mantissa divider: one quotient bit per clock, MSB first.
// Result q = floor((mant_a << 24) / mant_b), valid in the cycle after done_o.
module fp_div_mant_iter #(
  parameter int QBITS = 25
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [23:0]      mant_a_i,
  input  logic [23:0]      mant_b_i,
  output logic             done_o,
  output logic [QBITS-1:0] q_o
);
  localparam int CW = $clog2(QBITS);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [24:0]      rem_q, rem_d;
  logic [23:0]      mant_b_q, mant_b_d;
  logic [QBITS-1:0] q_q, q_d;
  logic             ge;
  logic [24:0]      trial;

  assign q_o = q_q;

  // Compare/subtract first, then shift: the first step weighs bit QBITS-1,
  // so q carries the extra normalisation bit when mant_a >= mant_b.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    mant_b_d = mant_b_q;
    q_d      = q_q;
    ge       = (rem_q >= {1'b0, mant_b_q});
    trial    = ge ? (rem_q - {1'b0, mant_b_q}) : rem_q;
    done_o   = busy_q && (cnt_q == CW'(QBITS - 1));
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      rem_d    = {1'b0, mant_a_i};
      mant_b_d = mant_b_i;
      q_d      = '0;
    end else if (busy_q) begin
      q_d   = {q_q[QBITS-2:0], ge};
      rem_d = trial << 1;
      cnt_d = cnt_q + 1'b1;
      if (done_o) busy_d = 1'b0;
    end
  end

  // Iteration state; reset aborts any division in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      mant_b_q <= '0;
      q_q      <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      mant_b_q <= mant_b_d;
      q_q      <= q_q == q_d ? q_q : q_d;
    end
  end
endmodule

// File: rtl/floatingpoint_divider.sv
// Iterative FP32 divider: data_o = dataA_i / dataB_i, truncating, no subnormals.
// Fixed 28-cycle cadence; special operands still run the full iteration.
module floatingpoint_divider
  import fp32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int QBITS      = 25
) (
  input logic                    clk_i,
  input logic                    rst_i,
  floatingpoint_divider_if.slave bus
);
  fpdiv_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dbz_q, dbz_d;
  logic                  valid_q, valid_d;

  logic                  start, it_done;
  logic [QBITS-1:0]      q;
  fp32_class_t           ca, cb;
  logic                  sign;
  logic signed [9:0]     e;
  logic [22:0]           man;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_dbz;

  assign start       = (state_q == ST_IDLE) && bus.valid_i;
  assign bus.ready_o = (state_q == ST_IDLE);
  assign bus.data_o  = data_q;
  assign bus.dbz_o   = dbz_q;
  assign bus.valid_o = valid_q;

  fp_div_mant_iter #(.QBITS(QBITS)) u_iter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start),
    .mant_a_i ({1'b1, bus.dataA_i[MAN_MSB:MAN_LSB]}),
    .mant_b_i ({1'b1, bus.dataB_i[MAN_MSB:MAN_LSB]}),
    .done_o   (it_done),
    .q_o      (q)
  );

  // Classification, exponent arithmetic, normalisation and packing.
  always_comb begin
    ca   = fp32_classify(a_q);
    cb   = fp32_classify(b_q);
    sign = a_q[SIGN_BIT] ^ b_q[SIGN_BIT];
    e    = $signed({2'b00, a_q[EXP_MSB:EXP_LSB]}) - $signed({2'b00, b_q[EXP_MSB:EXP_LSB]})
         + (q[QBITS-1] ? 10'(FP32_BIAS) : 10'(FP32_BIAS - 1));
    man  = q[QBITS-1] ? q[23:1] : q[22:0];
    res_dbz = 1'b0;
    if (ca.nan || cb.nan || (ca.inf && cb.inf) || (ca.zero && cb.zero)) begin
      res = QNAN;
    end else if (cb.zero && !ca.inf) begin
      res     = {sign, 8'hFF, 23'd0};
      res_dbz = 1'b1;
    end else if (ca.inf || cb.zero) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (ca.zero || cb.inf) begin
      res = {sign, 31'd0};
    end else if (e >= $signed(10'(EXP_MAX))) begin
      res = {sign, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      res = {sign, 31'd0};
    end else begin
      res = {sign, e[7:0], man};
    end
  end

  // Sequencing: accept in IDLE, wait out the iteration, pack, pulse valid.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    dbz_d   = dbz_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.valid_i) begin
        a_d     = bus.dataA_i;
        b_d     = bus.dataB_i;
        state_d = ST_DIVIDE;
      end
      ST_DIVIDE: if (it_done) state_d = ST_NORMALIZE;
      ST_NORMALIZE: begin
        data_d  = res;
        dbz_d   = res_dbz;
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset wins over a simultaneous valid_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_floatingpoint_divider.sv
// Directed-vector bench for the FP32 divider plus reset/handshake sequences.
module tb_floatingpoint_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  floatingpoint_divider_if #(.DATA_WIDTH(32)) bus ();

  floatingpoint_divider #(.DATA_WIDTH(32), .QBITS(25)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        dbz;
    string       name;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  // Issue one division and report the result and edges from accept to valid_o.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name,
                        output logic [31:0] q, output logic dbz, output int lat);
    int w;
    w   = 0;
    q   = '0;
    dbz = 1'b0;
    lat = -1;
    while (!bus.ready_o && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_ready_wait"}, 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.dataA_i = a;
    bus.dataB_i = b;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk({name, "_busy"}, 32'(bus.ready_o), 32'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.valid_o) begin
        lat = k;
        q   = bus.data_o;
        dbz = bus.dbz_o;
        break;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd26);
    @(posedge clk); #1;
    chk({name, "_pulse_end"}, 32'(bus.valid_o), 32'd0);
    chk({name, "_ready_after"}, 32'(bus.ready_o), 32'd1);
    chk({name, "_hold"}, bus.data_o, q);
  endtask

  initial begin
    logic [31:0] q;
    logic        dbz;
    int          lat;
    int          seen;
    int          nv;
    int          v_at[2];
    logic [31:0] v_data[2];

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "one_div_one"};
    vecs[1]  = '{32'h40C00000, 32'hC0000000, 32'hC0400000, 1'b0, "six_div_m2"};
    vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, "one_third"};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "one_div_zero"};
    vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, "zero_div_zero"};
    vecs[5]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, "inf_div_one"};
    vecs[6]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, "overflow"};
    vecs[7]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, "underflow"};
    vecs[8]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, "nan_in"};
    vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, "inf_div_inf"};
    vecs[10] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, "mzero_div_one"};
    vecs[11] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, "one_div_minf"};
    vecs[12] = '{32'hC0000000, 32'h00000000, 32'hFF800000, 1'b1, "m2_div_zero"};
    vecs[13] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, "inf_div_zero"};
    vecs[14] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, "exp_255"};
    vecs[15] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, "exp_254"};
    vecs[16] = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, "exp_0"};
    vecs[17] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, "exp_1"};
    vecs[18] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, "zero_dirty_man"};
    vecs[19] = '{32'h3F800000, 32'h80000005, 32'hFF800000, 1'b1, "div_mzero_dirty"};
    vecs[20] = '{32'h3FC00000, 32'h3FA00000, 32'h3F999999, 1'b0, "1p5_div_1p25"};

    bus.valid_i = 1'b0;
    bus.dataA_i = '0;
    bus.dataB_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", bus.data_o, 32'h0);
    chk("reset_valid", 32'(bus.valid_o), 32'd0);
    chk("reset_dbz", 32'(bus.dbz_o), 32'd0);
    chk("reset_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].name, q, dbz, lat);
      chk({vecs[i].name, "_data"}, q, vecs[i].q);
      chk({vecs[i].name, "_dbz"}, 32'(dbz), 32'(vecs[i].dbz));
    end

    // Reset during DIVIDE (cycle T+10) aborts the operation.
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.dataA_i = 32'h40C00000;
    bus.dataB_i = 32'hC0000000;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_data", bus.data_o, 32'h0);
    chk("abort_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    run_op(32'h40C00000, 32'hC0000000, "after_abort", q, dbz, lat);
    chk("after_abort_data", q, 32'hC0400000);

    // Reset together with valid_i: operands dropped.
    @(negedge clk);
    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.dataA_i = 32'h3F800000;
    bus.dataB_i = 32'h3F800000;
    @(posedge clk); #1;
    @(negedge clk);
    rst         = 1'b0;
    bus.valid_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.valid_o) seen++;
    end
    chk("rst_valid_no_result", 32'(seen), 32'd0);
    chk("rst_valid_data", bus.data_o, 32'h0);
    chk("rst_valid_ready", 32'(bus.ready_o), 32'd1);

    // valid_i held high: only operands present in IDLE cycles are taken.
    nv = 0;
    v_at[0] = -1;
    v_at[1] = -1;
    v_data[0] = '0;
    v_data[1] = '0;
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.dataA_i = 32'h40C00000;
    bus.dataB_i = 32'hC0000000;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.dataA_i = (k == 28) ? 32'h3F800000 : 32'h3F800000 + 32'(k);
      bus.dataB_i = (k == 28) ? 32'h40400000 : 32'h00000000;
      @(posedge clk); #1;
      if (bus.valid_o) begin
        if (nv < 2) begin
          v_at[nv]   = k;
          v_data[nv] = bus.data_o;
        end
        nv++;
      end
    end
    bus.valid_i = 1'b0;
    chk("stream_count", 32'(nv), 32'd2);
    chk("stream_first_at", 32'(v_at[0]), 32'd26);
    chk("stream_second_at", 32'(v_at[1]), 32'd54);
    chk("stream_first_data", v_data[0], 32'hC0400000);
    chk("stream_second_data", v_data[1], 32'h3EAAAAAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
